// File: rtl/counter_sat_param.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sat_param
//  Purpose  : Parametrised up/down counter between START and LIMIT with a
//             saturating (HOLD until clear) or cyclic mode, synchronous
//             clamped load, and a decoded match output.
//  Ports    : clk       - rising-edge clock
//             rst_n     - synchronous active-low reset
//             en        - count enable
//             up        - 1 = count toward LIMIT, 0 = count toward START
//             clear     - restart request, honoured only in HOLD
//             load      - synchronous load strobe (highest after reset)
//             load_val  - value to load, clamped to [START, LIMIT]
//             count     - registered count
//             out       - high while count == MATCH
//             done      - high while in HOLD (saturating mode only)
//             wrapped   - one-cycle pulse after a cyclic wrap
//  Revision : 1.0 - initial release
// ============================================================================
module counter_sat_param #(
   parameter int WIDTH = 3,
   parameter int START = 0,
   parameter int LIMIT = 7,
   parameter int MATCH = 4,
   parameter int WRAP  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             out,
   output logic             done,
   output logic             wrapped
);

   localparam logic [WIDTH-1:0] c_START = WIDTH'(START);
   localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);
   localparam logic [WIDTH-1:0] c_MATCH = WIDTH'(MATCH);
   localparam logic             c_WRAP  = (WRAP != 0);

   localparam logic [0:0] S_RUN  = 1'b0;
   localparam logic [0:0] S_HOLD = 1'b1;

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_wrapped;

   logic [WIDTH-1:0] w_term;
   logic [WIDTH-1:0] w_restart;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_lo_clamped;
   logic [WIDTH-1:0] w_clamped;

   // Endpoints follow the direction presented in the current cycle.
   assign w_term    = up ? c_LIMIT : c_START;
   assign w_restart = up ? c_START : c_LIMIT;
   assign w_next    = up ? (r_count + 1'b1) : (r_count - 1'b1);

   // Clamp comparisons are only built when the bound is not the natural
   // edge of the register, so no always-false compare is elaborated.
   if (START == 0) begin : g_lo_none
      assign w_lo_clamped = load_val;
   end else begin : g_lo_clamp
      assign w_lo_clamped = (load_val < c_START) ? c_START : load_val;
   end

   if (LIMIT == (2**WIDTH) - 1) begin : g_hi_none
      assign w_clamped = w_lo_clamped;
   end else begin : g_hi_clamp
      assign w_clamped = (w_lo_clamped > c_LIMIT) ? c_LIMIT : w_lo_clamped;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count   <= c_START;
         r_state   <= S_RUN;
         r_wrapped <= 1'b0;
      end else begin
         r_wrapped <= 1'b0;
         if (load) begin
            r_count <= w_clamped;
            r_state <= (!c_WRAP && (w_clamped == w_term)) ? S_HOLD : S_RUN;
         end else if (r_state == S_HOLD) begin
            if (clear) begin
               r_count <= w_restart;
               r_state <= S_RUN;
            end
         end else if (en) begin
            if (r_count != w_term) begin
               r_count <= w_next;
               // Enter HOLD on the same edge so done aligns with term.
               if (!c_WRAP && (w_next == w_term)) begin
                  r_state <= S_HOLD;
               end
            end else if (c_WRAP) begin
               r_count   <= w_restart;
               r_wrapped <= 1'b1;
            end else begin
               // Already at term (direction flip): saturate in place.
               r_state <= S_HOLD;
            end
         end
      end
   end

   assign count   = r_count;
   assign out     = (r_count == c_MATCH);
   assign done    = (r_state == S_HOLD);
   assign wrapped = r_wrapped;

endmodule
`default_nettype wire
